// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: filters per-device connect/disconnect pulses and
// serialises surviving events round-robin onto a single change/on_off pair.
module iot_event_arbiter #(
  parameter int N_DEV = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_connect,
  input  logic [N_DEV-1:0] dev_disconnect,
  output logic             change,
  output logic             on_off,
  output logic [N_DEV-1:0] dev_online,
  output logic             busy
);

  localparam int CW = PTR_W + 1;

  logic [N_DEV-1:0] target;
  logic [N_DEV-1:0] pending;
  logic [N_DEV-1:0] target_nxt;
  logic [N_DEV-1:0] online_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_nxt;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic [CW-1:0]    scan;

  // a device is pending exactly when its target differs from what was reported
  assign pending = target ^ dev_online;
  assign busy    = |pending;

  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int j = N_DEV - 1; j >= 0; j--) begin
      scan = {1'b0, rr_ptr} + CW'(j);
      if (scan >= CW'(N_DEV))
        scan = scan - CW'(N_DEV);
      if (pending[scan[PTR_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (gnt_vld) begin
      if (gnt_idx == PTR_W'(N_DEV - 1))
        rr_nxt = '0;
      else
        rr_nxt = gnt_idx + 1'b1;
    end
  end

  always_comb begin
    online_nxt = dev_online;
    if (gnt_vld)
      online_nxt[gnt_idx] = target[gnt_idx];
  end

  // grant never moves target, so filtering after it sees the same target;
  // an opposite request on the granted device re-opens a pending event
  always_comb begin
    target_nxt = target;
    for (int i = 0; i < N_DEV; i++) begin
      unique case ({dev_connect[i], dev_disconnect[i]})
        2'b10:   target_nxt[i] = 1'b1;
        2'b01:   target_nxt[i] = 1'b0;
        default: target_nxt[i] = target[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target     <= '0;
      dev_online <= '0;
      rr_ptr     <= '0;
      change     <= 1'b0;
      on_off     <= 1'b0;
    end else begin
      target     <= target_nxt;
      dev_online <= online_nxt;
      rr_ptr     <= rr_nxt;
      change     <= gnt_vld;
      on_off     <= gnt_vld & target[gnt_idx];
    end
  end

endmodule

// File: tb/tb_iot_event_arbiter.sv
// tb_iot_event_arbiter: scoreboard bench for iot_event_arbiter,
// expected events are queued at stimulus time and popped per change pulse.
module tb_iot_event_arbiter;

  typedef struct packed {
    logic [3:0] dev;
    logic       dir;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [3:0] dev_connect;
  logic [3:0] dev_disconnect;
  logic       change;
  logic       on_off;
  logic [3:0] dev_online;
  logic       busy;

  ev_t        q[$];
  int         n_chk;
  int         n_err;
  logic [3:0] prev_online;

  iot_event_arbiter #(.N_DEV(4), .PTR_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .dev_connect    (dev_connect),
    .dev_disconnect (dev_disconnect),
    .change         (change),
    .on_off         (on_off),
    .dev_online     (dev_online),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int dev, input logic dir);
    ev_t e;
    e.dev = 4'(dev);
    e.dir = dir;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    logic [3:0] flip;
    flip = dev_online ^ prev_online;
    prev_online = dev_online;
    if (rst && change) begin
      if (q.size() == 0) begin
        chk("spurious_change", 32'(change), 32'd0);
      end else begin
        e = q.pop_front();
        chk("ev_dir", 32'(on_off), 32'(e.dir));
        chk("ev_dev", 32'(flip), 32'(4'b0001 << e.dev));
      end
    end else if (rst) begin
      chk("onoff_idle", 32'(on_off), 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] c, input logic [3:0] d);
    dev_connect    = c;
    dev_disconnect = d;
    @(posedge clk);
    #1;
    dev_connect    = '0;
    dev_disconnect = '0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !busy)
        done = 1'b1;
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    dev_connect    = '0;
    dev_disconnect = '0;
    rst = 1'b0;
    q.delete();
    cyc(2);
    rst = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    prev_online = '0;
    rst = 1'b0;
    dev_connect = '0;
    dev_disconnect = '0;
    cyc(1);
    chk("rst_change", 32'(change), 32'd0);
    chk("rst_online", 32'(dev_online), 32'd0);
    do_reset();
    cyc(1);

    // async reset mid-burst
    pulse(4'b0101, 4'b0000);
    push(0, 1'b1);
    push(2, 1'b1);
    drain("rst_pre");
    chk("rst_pre_online", 32'(dev_online), 32'h5);
    pulse(4'b0010, 4'b0000);
    chk("rst_pend_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_change", 32'(change), 32'd0);
    chk("rst_async_onoff", 32'(on_off), 32'd0);
    chk("rst_async_online", 32'(dev_online), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    q.delete();
    cyc(2);
    rst = 1'b1;
    cyc(6);
    chk("rst_after_online", 32'(dev_online), 32'd0);

    // single event latency
    do_reset();
    cyc(1);
    pulse(4'b0100, 4'b0000);
    push(2, 1'b1);
    chk("single_k_change", 32'(change), 32'd0);
    chk("single_k_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("single_k1_change", 32'(change), 32'd1);
    chk("single_k1_onoff", 32'(on_off), 32'd1);
    chk("single_k1_online", 32'(dev_online), 32'h4);
    chk("single_k1_busy", 32'(busy), 32'd0);
    cyc(1);
    chk("single_k2_change", 32'(change), 32'd0);
    drain("single");

    // burst and round-robin
    do_reset();
    cyc(1);
    pulse(4'hF, 4'h0);
    for (int i = 0; i < 4; i++) push(i, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("burst_consec", 32'(change), 32'd1);
    end
    drain("burst");
    chk("burst_online", 32'(dev_online), 32'hF);
    pulse(4'h0, 4'hF);
    for (int i = 0; i < 4; i++) push(i, 1'b0);
    drain("burst_off");
    chk("burst_off_online", 32'(dev_online), 32'h0);

    // cancellation before grant
    do_reset();
    cyc(1);
    pulse(4'hF, 4'h0);
    pulse(4'h0, 4'h8);
    for (int i = 0; i < 3; i++) push(i, 1'b1);
    drain("cancel");
    cyc(5);
    chk("cancel_online", 32'(dev_online), 32'h7);

    // redundant and conflicting requests
    do_reset();
    cyc(1);
    pulse(4'b0001, 4'b0000);
    push(0, 1'b1);
    drain("redun_pre");
    pulse(4'b0001, 4'b0000);
    pulse(4'b0000, 4'b0010);
    pulse(4'b0100, 4'b0100);
    chk("redun_busy", 32'(busy), 32'd0);
    cyc(5);
    chk("redun_online", 32'(dev_online), 32'h1);

    // collision on the grant edge
    do_reset();
    cyc(1);
    pulse(4'b0010, 4'b0000);
    pulse(4'b0000, 4'b0010);
    push(1, 1'b1);
    push(1, 1'b0);
    chk("coll_on_change", 32'(change), 32'd1);
    chk("coll_on_dir", 32'(on_off), 32'd1);
    cyc(1);
    chk("coll_off_change", 32'(change), 32'd1);
    chk("coll_off_dir", 32'(on_off), 32'd0);
    drain("coll");
    chk("coll_online", 32'(dev_online), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
